// File: rtl/prio_enc_rr.sv
// Registered N-input priority encoder: captures requests into a pending set and
// drains one index per accepted transfer, in fixed-priority or round-robin order.
module prio_enc_rr #(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic [W-1:0] y,
  output logic         valid,
  output logic [N-1:0] pend,
  output logic         idle
);

  logic [N-1:0] reqm;
  logic [N-1:0] cand;
  logic [N-1:0] sel_oh;
  logic [W-1:0] sel;
  logic [W-1:0] sel_fix;
  logic [W-1:0] sel_rr;
  logic [W-1:0] ptr;
  logic         accept;
  logic         load;

  assign reqm   = en ? req : '0;
  assign cand   = pend | reqm;
  assign accept = valid & ready;
  assign load   = en & (~valid | ready);
  assign idle   = (pend == '0) && !valid;

  // Fixed priority: the highest set index wins.
  always_comb begin
    sel_fix = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cand[i]) sel_fix = W'(i);
    end
  end

  // Round robin: descending scan starting just below the last grant, wrapping modulo N.
  always_comb begin
    logic        found;
    int unsigned idx;
    sel_rr = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + N - 1 - i) % N;
      if (!found && cand[W'(idx)]) begin
        sel_rr = W'(idx);
        found  = 1'b1;
      end
    end
  end

  assign sel    = mode ? sel_rr : sel_fix;
  assign sel_oh = {{(N-1){1'b0}}, 1'b1} << sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= '0;
      valid <= 1'b0;
      pend  <= '0;
      ptr   <= '0;
    end else if (load) begin
      if (cand != '0) begin
        y     <= sel;
        valid <= 1'b1;
        ptr   <= sel;
        pend  <= cand & ~sel_oh;
      end else begin
        y     <= '0;
        valid <= 1'b0;
        pend  <= '0;
      end
    end else begin
      pend <= pend | reqm;
      // Only reachable with en low: the consumer drains the held grant.
      if (accept) begin
        y     <= '0;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prio_enc_rr.sv
// Scenario bench for prio_enc_rr: expected grant indices are queued when stimulus
// is driven and popped as each transfer is observed.
module tb_prio_enc_rr;
  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b1;
  logic         mode = 1'b0;
  logic [N-1:0] req = '0;
  logic         ready = 1'b0;
  logic [W-1:0] y;
  logic         valid;
  logic [N-1:0] pend;
  logic         idle;

  int passed = 0;
  int total  = 0;
  int exp_q[$];

  prio_enc_rr #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .req(req),
    .ready(ready), .y(y), .valid(valid), .pend(pend), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    en = 1'b1; ready = 1'b1; rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req = (k % 2 == 0) ? 8'hFF : 8'h00;
      step();
      total++;
      if (y !== '0 || valid !== 1'b0 || pend !== '0 || idle !== 1'b1)
        $display("FAIL reset_hold[%0d]: y=%0d valid=%b pend=%h idle=%b, expected 0 0 00 1",
                 k, y, valid, pend, idle);
      else passed++;
    end
    req = '0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fixed_drain();
    int e;
    mode = 1'b0; ready = 1'b1; en = 1'b1;
    req = 8'b0010_0110;
    exp_q.push_back(5); exp_q.push_back(2); exp_q.push_back(1);
    step();
    req = '0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (!valid || exp_q.size() == 0)
        $display("FAIL fixed_drain[%0d]: valid=%b queued=%0d, expected a grant", k, valid, exp_q.size());
      else begin
        e = exp_q.pop_front();
        if (32'(y) !== e) $display("FAIL fixed_drain[%0d]: y=%0d expected %0d", k, y, e);
        else passed++;
      end
      step();
    end
    total++;
    if (valid !== 1'b0 || idle !== 1'b1)
      $display("FAIL fixed_drain_end: valid=%b idle=%b, expected 0 1", valid, idle);
    else passed++;
  endtask

  task automatic test_rr_fairness();
    int e;
    apply_reset();
    mode = 1'b1; ready = 1'b1;
    req = 8'hFF;
    for (int r = 0; r < 2; r++)
      for (int i = N - 1; i >= 0; i--) exp_q.push_back(i);
    step();
    for (int k = 0; k < 2 * N; k++) begin
      total++;
      if (!valid || exp_q.size() == 0)
        $display("FAIL rr_fair[%0d]: valid=%b queued=%0d, expected a grant", k, valid, exp_q.size());
      else begin
        e = exp_q.pop_front();
        if (32'(y) !== e) $display("FAIL rr_fair[%0d]: y=%0d expected %0d", k, y, e);
        else passed++;
      end
      step();
    end
    req = '0;
    mode = 1'b0;
    apply_reset();
  endtask

  task automatic test_backpressure();
    int e;
    mode = 1'b0; ready = 1'b0;
    req = 8'h09;
    step();
    req = '0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (y !== 3'd3 || valid !== 1'b1 || pend !== 8'h01)
        $display("FAIL bp_stall[%0d]: y=%0d valid=%b pend=%h, expected 3 1 01", k, y, valid, pend);
      else passed++;
      step();
    end
    req = 8'h08;
    step();
    req = '0;
    total++;
    if (y !== 3'd3 || valid !== 1'b1 || pend !== 8'h09)
      $display("FAIL bp_rereq: y=%0d valid=%b pend=%h, expected 3 1 09", y, valid, pend);
    else passed++;
    ready = 1'b1;
    exp_q.push_back(3); exp_q.push_back(3); exp_q.push_back(0);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (!valid || exp_q.size() == 0)
        $display("FAIL bp_drain[%0d]: valid=%b queued=%0d, expected a grant", k, valid, exp_q.size());
      else begin
        e = exp_q.pop_front();
        if (32'(y) !== e) $display("FAIL bp_drain[%0d]: y=%0d expected %0d", k, y, e);
        else passed++;
      end
      step();
    end
    total++;
    if (valid !== 1'b0 || y !== '0)
      $display("FAIL bp_end: valid=%b y=%0d, expected 0 0", valid, y);
    else passed++;
  endtask

  task automatic test_enable_gating();
    en = 1'b0; ready = 1'b1;
    req = 8'hFF;
    step();
    req = '0;
    step();
    total++;
    if (pend !== '0 || valid !== 1'b0)
      $display("FAIL en_block: pend=%h valid=%b, expected 00 0", pend, valid);
    else passed++;
    en = 1'b1; ready = 1'b0;
    req = 8'h04;
    step();
    req = '0;
    total++;
    if (valid !== 1'b1 || y !== 3'd2)
      $display("FAIL en_grant: valid=%b y=%0d, expected 1 2", valid, y);
    else passed++;
    en = 1'b0; ready = 1'b1;
    step();
    total++;
    if (valid !== 1'b0 || y !== '0 || pend !== '0)
      $display("FAIL en_drain: valid=%b y=%0d pend=%h, expected 0 0 00", valid, y, pend);
    else passed++;
    en = 1'b1;
    step();
  endtask

  task automatic test_reset_midop();
    mode = 1'b0; ready = 1'b0;
    req = 8'h70;
    step();
    req = '0;
    total++;
    if (valid !== 1'b1 || y !== 3'd6 || pend !== 8'h30)
      $display("FAIL midop_setup: valid=%b y=%0d pend=%h, expected 1 6 30", valid, y, pend);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (valid !== 1'b0 || pend !== '0 || y !== '0)
      $display("FAIL midop_async: valid=%b pend=%h y=%0d, expected 0 00 0", valid, pend, y);
    else passed++;
    step();
    rst_n = 1'b1;
    ready = 1'b1;
    step();
    step();
    total++;
    if (idle !== 1'b1 || valid !== 1'b0)
      $display("FAIL midop_idle: idle=%b valid=%b, expected 1 0", idle, valid);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fixed_drain();
    test_rr_fairness();
    test_backpressure();
    test_enable_gating();
    test_reset_midop();
    total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_left: %0d entries remain, expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
